// File: rtl/lanzones_lsu_if.sv
// rtl/lanzones_lsu_if.sv - word-addressed memory bus between the lanzones LSU and memory
interface lanzones_lsu_if;
  logic        RRdy;
  logic [31:0] RAddr;
  logic [31:0] RWData;
  logic        RWEn;
  logic [3:0]  RWStrobe;
  logic        RVld;
  logic [31:0] RData;

  modport master (
    output RRdy, RAddr, RWData, RWEn, RWStrobe,
    input  RVld, RData
  );

  modport slave (
    input  RRdy, RAddr, RWData, RWEn, RWStrobe,
    output RVld, RData
  );
endinterface

// File: rtl/lanzones_lsu.sv
// rtl/lanzones_lsu.sv - RV32I load/store unit with alignment check and bus watchdog
module lanzones_lsu #(
  parameter int TIMEOUT_CYC = 255,
  parameter int TO_W        = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_err,
  lanzones_lsu_if.master bus
);

  typedef enum logic [1:0] {IDLE, BUS, RSP} state_t;

  localparam bit            TO_EN   = (TIMEOUT_CYC != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  state_t          state, state_n;
  logic [TO_W-1:0] to_cnt;
  logic            accept, illegal, misaligned, req_bad, timeout_hit, leaving_bus;
  logic [3:0]      st_strobe;
  logic [31:0]     st_data;
  logic [2:0]      f3_q;
  logic [1:0]      alo_q;
  logic [31:0]     ld_word, ld_ext;

  assign req_ready   = (state == IDLE) && rstn;
  assign rsp_valid   = (state == RSP);
  assign accept      = req_valid && req_ready;
  assign req_bad     = illegal || misaligned;
  assign timeout_hit = TO_EN && (to_cnt == TO_LAST);
  assign leaving_bus = (state == BUS) && (state_n != BUS);

  // Request decode: legality of funct3 per direction, then natural alignment by size.
  always_comb begin
    illegal = 1'b0;
    case (req_funct3)
      3'd0, 3'd1, 3'd2: illegal = 1'b0;
      3'd4, 3'd5:       illegal = req_we;
      default:          illegal = 1'b1;
    endcase
    misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  end

  // Store lane placement: strobe shifted to the byte offset, data replicated across lanes.
  always_comb begin
    st_strobe = 4'b0000;
    st_data   = 32'd0;
    if (req_we) begin
      case (req_funct3[1:0])
        2'b00:   begin st_strobe = 4'b0001 << req_addr[1:0]; st_data = {4{req_wdata[7:0]}};  end
        2'b01:   begin st_strobe = 4'b0011 << req_addr[1:0]; st_data = {2{req_wdata[15:0]}}; end
        default: begin st_strobe = 4'b1111;                  st_data = req_wdata;            end
      endcase
    end
  end

  // Load extraction: shift the addressed lane down, then sign- or zero-extend by funct3.
  always_comb begin
    ld_word = bus.RData >> {alo_q, 3'b000};
    ld_ext  = ld_word;
    case (f3_q)
      3'd0:    ld_ext = {{24{ld_word[7]}}, ld_word[7:0]};
      3'd4:    ld_ext = {24'd0, ld_word[7:0]};
      3'd1:    ld_ext = {{16{ld_word[15]}}, ld_word[15:0]};
      3'd5:    ld_ext = {16'd0, ld_word[15:0]};
      default: ld_ext = ld_word;
    endcase
  end

  // Next-state logic; a bus completion beats a simultaneous watchdog expiry.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept) state_n = req_bad ? RSP : BUS;
      BUS:  if (bus.RVld || timeout_hit) state_n = RSP;
      RSP:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_n;
  end

  // Watchdog counter: cleared on accept, counts BUS cycles without a completion.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                              to_cnt <= '0;
    else if (accept)                        to_cnt <= '0;
    else if ((state == BUS) && !bus.RVld)   to_cnt <= to_cnt + 1'b1;
  end

  // Registered bus outputs: loaded on a good accept, held through BUS, cleared on exit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.RRdy     <= 1'b0;
      bus.RAddr    <= 32'd0;
      bus.RWData   <= 32'd0;
      bus.RWEn     <= 1'b0;
      bus.RWStrobe <= 4'b0000;
    end else if (accept && !req_bad) begin
      bus.RRdy     <= 1'b1;
      bus.RAddr    <= {2'b00, req_addr[31:2]};
      bus.RWData   <= st_data;
      bus.RWEn     <= req_we;
      bus.RWStrobe <= st_strobe;
    end else if (leaving_bus) begin
      bus.RRdy     <= 1'b0;
      bus.RAddr    <= 32'd0;
      bus.RWData   <= 32'd0;
      bus.RWEn     <= 1'b0;
      bus.RWStrobe <= 4'b0000;
    end
  end

  // Request context needed later to extract load data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      f3_q  <= 3'd0;
      alo_q <= 2'd0;
    end else if (accept) begin
      f3_q  <= req_we ? 3'd2 : req_funct3;
      alo_q <= req_addr[1:0];
    end
  end

  // Response payload: written on the edge entering RSP and held until the next one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_rdata <= 32'd0;
      rsp_err   <= 2'b00;
    end else if (accept && req_bad) begin
      rsp_rdata <= 32'd0;
      rsp_err   <= illegal ? 2'b11 : 2'b01;
    end else if ((state == BUS) && bus.RVld) begin
      rsp_rdata <= bus.RWEn ? 32'd0 : ld_ext;
      rsp_err   <= 2'b00;
    end else if ((state == BUS) && timeout_hit) begin
      rsp_rdata <= 32'd0;
      rsp_err   <= 2'b10;
    end
  end

endmodule

// File: tb/tb_lanzones_lsu.sv
// tb/tb_lanzones_lsu.sv - directed self-checking bench for lanzones_lsu
module tb_lanzones_lsu;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;

  logic [31:0] mem [0:255];
  int n_tests = 0;
  int n_fail  = 0;

  lanzones_lsu_if bus_if ();

  lanzones_lsu #(.TIMEOUT_CYC(8), .TO_W(8)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic do_txn(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_raddr, input logic [3:0] exp_strb,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
    logic [7:0] idx;
    drive_req(we, f3, a, wd);
    check({tag, ".rrdy"},  {31'd0, bus_if.RRdy}, 32'd1);
    check({tag, ".raddr"}, bus_if.RAddr, exp_raddr);
    check({tag, ".strb"},  {28'd0, bus_if.RWStrobe}, {28'd0, exp_strb});
    check({tag, ".rwen"},  {31'd0, bus_if.RWEn}, {31'd0, we});
    if (we) check({tag, ".rwdata"}, bus_if.RWData, exp_wdata);
    @(posedge clk); #1;
    check({tag, ".hold_rrdy"}, {31'd0, bus_if.RRdy}, 32'd1);
    check({tag, ".hold_rwen"}, {31'd0, bus_if.RWEn}, {31'd0, we});
    check({tag, ".early_rsp"}, {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    idx = bus_if.RAddr[7:0];
    bus_if.RVld  = 1'b1;
    bus_if.RData = mem[idx];
    if (bus_if.RWEn)
      for (int i = 0; i < 4; i++)
        if (bus_if.RWStrobe[i]) mem[idx][8*i +: 8] = bus_if.RWData[8*i +: 8];
    @(posedge clk); #1;
    check({tag, ".rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
    check({tag, ".rdata"},     rsp_rdata, exp_rdata);
    check({tag, ".err"},       {30'd0, rsp_err}, 32'd0);
    check({tag, ".rrdy_drop"}, {31'd0, bus_if.RRdy}, 32'd0);
    @(negedge clk);
    bus_if.RVld = 1'b0;
    @(posedge clk); #1;
    check({tag, ".rsp_pulse"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  task automatic do_err(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [1:0] exp_err);
    drive_req(we, f3, a, 32'h5555_5555);
    check({tag, ".rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
    check({tag, ".err"},       {30'd0, rsp_err}, {30'd0, exp_err});
    check({tag, ".rdata"},     rsp_rdata, 32'd0);
    check({tag, ".rrdy"},      {31'd0, bus_if.RRdy}, 32'd0);
    @(posedge clk); #1;
    check({tag, ".rrdy2"},     {31'd0, bus_if.RRdy}, 32'd0);
    check({tag, ".rsp_pulse"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, ".ready"},     {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[8'h40] = 32'h80FF_1234;
    bus_if.RVld  = 1'b0;
    bus_if.RData = 32'd0;

    #12;
    check("rst.rrdy",      {31'd0, bus_if.RRdy}, 32'd0);
    check("rst.rwen",      {31'd0, bus_if.RWEn}, 32'd0);
    check("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst.req_ready", {31'd0, req_ready}, 32'd0);
    check("rst.rdata",     rsp_rdata, 32'd0);
    @(negedge clk); rstn = 1'b1; #1;
    check("rst.ready_after", {31'd0, req_ready}, 32'd1);

    do_txn("lb",  1'b0, 3'd0, 32'h103, 32'd0, 32'h40, 4'b0000, 32'd0, 32'hFFFF_FF80);
    do_txn("lbu", 1'b0, 3'd4, 32'h103, 32'd0, 32'h40, 4'b0000, 32'd0, 32'h0000_0080);
    do_txn("lhu", 1'b0, 3'd5, 32'h102, 32'd0, 32'h40, 4'b0000, 32'd0, 32'h0000_80FF);
    do_txn("sb",  1'b1, 3'd0, 32'h101, 32'h0000_00AB, 32'h40, 4'b0010, 32'hABAB_ABAB, 32'd0);
    do_txn("lw_rb", 1'b0, 3'd2, 32'h100, 32'd0, 32'h40, 4'b0000, 32'd0, 32'h80FF_AB34);
    do_txn("lh",  1'b0, 3'd1, 32'h102, 32'd0, 32'h40, 4'b0000, 32'd0, 32'hFFFF_80FF);
    do_txn("sw",  1'b1, 3'd2, 32'h104, 32'hDEAD_BEEF, 32'h41, 4'b1111, 32'hDEAD_BEEF, 32'd0);
    do_txn("sh",  1'b1, 3'd1, 32'h106, 32'h0000_CAFE, 32'h41, 4'b1100, 32'hCAFE_CAFE, 32'd0);
    do_txn("lh_hi", 1'b0, 3'd1, 32'h106, 32'd0, 32'h41, 4'b0000, 32'd0, 32'hFFFF_CAFE);

    do_err("misal_lw", 1'b0, 3'd2, 32'h102, 2'b01);
    do_err("misal_lh", 1'b0, 3'd1, 32'h101, 2'b01);
    do_err("ill_ld3",  1'b0, 3'd3, 32'h100, 2'b11);
    do_err("ill_st4",  1'b1, 3'd4, 32'h101, 2'b11);

    drive_req(1'b0, 3'd2, 32'h100, 32'd0);
    check("to.rrdy", {31'd0, bus_if.RRdy}, 32'd1);
    for (int i = 0; i < 7; i++) @(posedge clk);
    #1;
    check("to.rrdy_7", {31'd0, bus_if.RRdy}, 32'd1);
    check("to.rsp_7",  {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    check("to.rrdy_8",  {31'd0, bus_if.RRdy}, 32'd0);
    check("to.rsp_8",   {31'd0, rsp_valid}, 32'd1);
    check("to.err",     {30'd0, rsp_err}, 32'd2);
    check("to.rdata",   rsp_rdata, 32'd0);
    @(posedge clk); #1;
    check("to.pulse",   {31'd0, rsp_valid}, 32'd0);
    check("to.hold_err", {30'd0, rsp_err}, 32'd2);

    drive_req(1'b1, 3'd2, 32'h108, 32'h1111_1111);
    check("ar.rrdy", {31'd0, bus_if.RRdy}, 32'd1);
    check("ar.rwen", {31'd0, bus_if.RWEn}, 32'd1);
    @(negedge clk); rstn = 1'b0; #1;
    check("ar.rrdy_low",  {31'd0, bus_if.RRdy}, 32'd0);
    check("ar.rwen_low",  {31'd0, bus_if.RWEn}, 32'd0);
    check("ar.rsp_low",   {31'd0, rsp_valid}, 32'd0);
    @(negedge clk); rstn = 1'b1; #1;
    check("ar.ready", {31'd0, req_ready}, 32'd1);
    do_txn("ar_lw", 1'b0, 3'd2, 32'h104, 32'd0, 32'h41, 4'b0000, 32'd0, 32'hCAFE_BEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
